// File: rtl/tff_pkg.sv
// Shared definitions for the time flip-flop bank.
//   tff_state_e : per-channel FSM state (idle / write / read)
//   MODE_WRAP   : overflow wraps the counter to zero and raises carry
//   MODE_SAT    : overflow clamps the counter at all-ones and raises carry
package tff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } tff_state_e;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

endpackage

// File: rtl/tff_chan.sv
// Single time flip-flop channel: records an interval as the number of cycles
// 'we' is high, and replays it on a rising edge of 're' as an 'out' pulse of
// the same length followed by a one-cycle 'done'.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   we       : write strobe (level), one count per cycle sampled high
//   re       : read strobe, rising edge starts replay
//   clr      : synchronous clear of count and carry (aborts a replay)
//   out      : registered replay pulse
//   done     : one-cycle pulse after a completed replay
//   carry    : sticky overflow flag
//   busy     : channel is in WRITE or READ
//   count    : held interval
module tff_chan
    import tff_pkg::*;
#(
    parameter int unsigned BITS     = 4,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic            re,
    input  logic            clr,
    output logic            out,
    output logic            done,
    output logic            carry,
    output logic            busy,
    output logic [BITS-1:0] count
);

    localparam logic [BITS-1:0] One = BITS'(1);

    tff_state_e      state_q, state_d;
    logic [BITS-1:0] count_q, count_d;
    logic            carry_q, carry_d;
    logic            out_q, out_d;
    logic            done_q, done_d;
    logic            re_q;

    logic            re_edge;
    logic            at_max;
    logic [BITS-1:0] count_inc;

    // re_q tracks re in every state, so an edge seen outside IDLE is lost
    assign re_edge = re & ~re_q;
    assign at_max  = &count_q;

    always_comb begin
        count_inc = count_q + One;
        if (at_max) begin
            count_inc = (SATURATE == MODE_SAT) ? count_q : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        carry_d = carry_q;
        out_d   = 1'b0;
        done_d  = 1'b0;

        if (clr) begin
            count_d = '0;
            carry_d = 1'b0;
            // A write in progress keeps going from zero; a replay is abandoned
            state_d = (state_q == ST_WRITE && we) ? ST_WRITE : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (we) begin
                        state_d = ST_WRITE;
                        count_d = count_inc;
                        if (at_max) carry_d = 1'b1;
                    end else if (re_edge) begin
                        if (count_q == '0) begin
                            // Empty interval: nothing to replay, finish at once
                            done_d  = 1'b1;
                            carry_d = 1'b0;
                        end else begin
                            state_d = ST_READ;
                            out_d   = 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (we) begin
                        count_d = count_inc;
                        if (at_max) carry_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_READ: begin
                    // count_q is the number of out cycles still owed, including this one
                    count_d = count_q - One;
                    if (count_q == One) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        carry_d = 1'b0;
                    end else begin
                        out_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            carry_q <= 1'b0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            carry_q <= carry_d;
            out_q   <= out_d;
            done_q  <= done_d;
            re_q    <= re;
        end
    end

    assign out   = out_q;
    assign done  = done_q;
    assign carry = carry_q;
    assign busy  = (state_q != ST_IDLE);
    assign count = count_q;

endmodule

// File: rtl/tff_bank.sv
// Bank of independent time flip-flop channels sharing only clk and rst.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   we/re/clr: per-channel write strobe, read strobe, clear
//   out/done : per-channel replay pulse and completion pulse
//   carry    : per-channel sticky overflow
//   busy     : per-channel activity flag
//   count    : packed held counts, channel i at [i*BITS +: BITS]
module tff_bank
    import tff_pkg::*;
#(
    parameter int unsigned BITS     = 4,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNELS-1:0]      we,
    input  logic [CHANNELS-1:0]      re,
    input  logic [CHANNELS-1:0]      clr,
    output logic [CHANNELS-1:0]      out,
    output logic [CHANNELS-1:0]      done,
    output logic [CHANNELS-1:0]      carry,
    output logic [CHANNELS-1:0]      busy,
    output logic [CHANNELS*BITS-1:0] count
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        tff_chan #(
            .BITS     (BITS),
            .SATURATE (SATURATE)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .we    (we[g]),
            .re    (re[g]),
            .clr   (clr[g]),
            .out   (out[g]),
            .done  (done[g]),
            .carry (carry[g]),
            .busy  (busy[g]),
            .count (count[g*BITS +: BITS])
        );
    end

endmodule

// File: tb/tb_tff_bank.sv
module tb_tff_bank;

    localparam int BITS = 4;
    localparam int CH   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     we, re, clr;
    logic [CH-1:0]     out, done, carry, busy;
    logic [CH*BITS-1:0] count;
    logic [CH-1:0]     s_out, s_done, s_carry, s_busy;
    logic [CH*BITS-1:0] s_count;

    tff_bank #(.BITS(BITS), .CHANNELS(CH), .SATURATE(0)) dut (
        .clk(clk), .rst(rst), .we(we), .re(re), .clr(clr),
        .out(out), .done(done), .carry(carry), .busy(busy), .count(count)
    );

    tff_bank #(.BITS(BITS), .CHANNELS(CH), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .we(we), .re(re), .clr(clr),
        .out(s_out), .done(s_done), .carry(s_carry), .busy(s_busy), .count(s_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int unsigned exp_len [CH][$];
    int run_len [CH];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int cnt(input int ch);
        return int'(count[ch*BITS +: BITS]);
    endfunction

    function automatic int scnt(input int ch);
        return int'(s_count[ch*BITS +: BITS]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int n);
        we[ch] = 1'b1;
        repeat (n) step();
        we[ch] = 1'b0;
        step();
    endtask

    task automatic wait_idle(input int ch);
        int t = 0;
        while (busy[ch] && t < 60) begin
            step();
            t++;
        end
        if (busy[ch]) begin
            checks++;
            failures++;
            $display("FAIL wait_idle ch%0d: busy=1 after %0d cycles, required 0", ch, t);
        end
    endtask

    task automatic rd(input int ch, input int len);
        exp_len[ch].push_back(len);
        re[ch] = 1'b1;
        step();
        re[ch] = 1'b0;
        wait_idle(ch);
        step();
    endtask

    // Monitor: measures each replay pulse and checks it when done appears
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) run_len[i] = 0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (out[i]) run_len[i]++;
                if (done[i]) begin
                    checks++;
                    if (exp_len[i].size() == 0) begin
                        failures++;
                        $display("FAIL done_ch%0d: unexpected done after %0d out cycles, required none",
                                 i, run_len[i]);
                    end else begin
                        int unsigned e;
                        e = exp_len[i].pop_front();
                        if (run_len[i] != int'(e)) begin
                            failures++;
                            $display("FAIL replay_len_ch%0d: got %0d expected %0d", i, run_len[i], e);
                        end
                    end
                    run_len[i] = 0;
                end else if (!busy[i]) begin
                    run_len[i] = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        we  = '0;
        re  = '0;
        clr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out", int'(out), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_carry", int'(carry), 0);
        rst = 1'b0;
        step();

        // 1: store 5, replay 5
        wr(0, 5);
        chk("t1_count", cnt(0), 5);
        exp_len[0].push_back(5);
        re[0] = 1'b1;
        step();
        chk("t1_out_start", int'(out[0]), 1);
        chk("t1_busy", int'(busy[0]), 1);
        re[0] = 1'b0;
        wait_idle(0);
        chk("t1_done", int'(done[0]), 1);
        step();
        chk("t1_count_after", cnt(0), 0);
        chk("t1_carry_after", int'(carry[0]), 0);

        // 2: accumulate 3 + 4
        wr(1, 3);
        wr(1, 4);
        chk("t2_count", cnt(1), 7);
        rd(1, 7);

        // 3: overflow, wrap vs saturate
        wr(2, 18);
        chk("t3_wrap_count", cnt(2), 2);
        chk("t3_wrap_carry", int'(carry[2]), 1);
        chk("t3_sat_count", scnt(2), 15);
        chk("t3_sat_carry", int'(s_carry[2]), 1);
        rd(2, 2);
        chk("t3_wrap_carry_clr", int'(carry[2]), 0);
        for (int t = 0; t < 40 && s_busy[2]; t++) step();
        chk("t3_sat_busy", int'(s_busy[2]), 0);
        chk("t3_sat_count_clr", scnt(2), 0);
        chk("t3_sat_carry_clr", int'(s_carry[2]), 0);

        // 4a: we and re edge together -> write wins
        wr(3, 2);
        we[3] = 1'b1;
        re[3] = 1'b1;
        step();
        chk("t4a_busy", int'(busy[3]), 1);
        chk("t4a_out", int'(out[3]), 0);
        we[3] = 1'b0;
        re[3] = 1'b0;
        step();
        chk("t4a_count", cnt(3), 3);
        // 4b: re edge during write is lost
        we[3] = 1'b1;
        step();
        re[3] = 1'b1;
        step();
        step();
        we[3] = 1'b0;
        step();
        re[3] = 1'b0;
        step();
        chk("t4b_count", cnt(3), 6);
        chk("t4b_busy", int'(busy[3]), 0);
        // 4c: we during read is ignored
        exp_len[3].push_back(6);
        re[3] = 1'b1;
        step();
        re[3] = 1'b0;
        we[3] = 1'b1;
        step();
        step();
        we[3] = 1'b0;
        wait_idle(3);
        step();
        chk("t4c_count", cnt(3), 0);

        // 5a: reset mid-read
        wr(0, 9);
        re[0] = 1'b1;
        step();
        re[0] = 1'b0;
        repeat (3) step();
        chk("t5a_out_before", int'(out[0]), 1);
        rst = 1'b1;
        #1;
        chk("t5a_out", int'(out[0]), 0);
        chk("t5a_busy", int'(busy[0]), 0);
        chk("t5a_count", cnt(0), 0);
        step();
        rst = 1'b0;
        step();
        // clr in idle
        wr(1, 3);
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        chk("t5_clr_idle", cnt(1), 0);
        // 5b: clr mid-read
        wr(1, 5);
        re[1] = 1'b1;
        step();
        re[1] = 1'b0;
        step();
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        chk("t5b_out", int'(out[1]), 0);
        chk("t5b_busy", int'(busy[1]), 0);
        chk("t5b_count", cnt(1), 0);
        step();
        step();

        // 6a: replay of an empty interval
        exp_len[2].push_back(0);
        re[2] = 1'b1;
        step();
        chk("t6a_done", int'(done[2]), 1);
        chk("t6a_out", int'(out[2]), 0);
        re[2] = 1'b0;
        step();
        chk("t6a_done_once", int'(done[2]), 0);
        // 6b: re held high does not retrigger
        wr(0, 3);
        exp_len[0].push_back(3);
        re[0] = 1'b1;
        repeat (20) step();
        re[0] = 1'b0;
        step();
        chk("t6b_count", cnt(0), 0);
        // 6c: all channels concurrently, lengths 2..5
        we = '1;
        for (int t = 1; t <= 5; t++) begin
            step();
            for (int i = 0; i < CH; i++) if (i + 2 == t) we[i] = 1'b0;
        end
        step();
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("t6c_count_ch%0d", i), cnt(i), i + 2);
            exp_len[i].push_back(i + 2);
        end
        re = '1;
        step();
        re = '0;
        for (int i = 0; i < CH; i++) wait_idle(i);
        step();
        step();

        for (int i = 0; i < CH; i++) begin
            chk($sformatf("pending_replays_ch%0d", i), exp_len[i].size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tff_bank.md
Name: tff_bank

Overview:
- Clocked, multi-channel successor to the ring-oscillator time flip-flop.
- Each channel stores a time interval by counting clock cycles while its write strobe is high.
- On a read strobe it replays the stored interval as an output pulse of identical length, then signals done.
- Sits between pulse-domain producers and consumers that need digitally held, replayable time intervals; saturating or wrap-with-carry overflow is selectable.

Parameters:
BITS, 4, width of each channel's interval counter (max interval 2**BITS-1 cycles)
CHANNELS, 4, number of independent channels
SATURATE, 0, 0 = counter wraps and sets sticky carry; 1 = counter clamps at all-ones and sets sticky carry

Ports:
clk  input  1  sole clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
we  input  CHANNELS  per-channel write strobe, level; interval = cycles sampled high
re  input  CHANNELS  per-channel read strobe, rising edge triggers replay
clr  input  CHANNELS  per-channel synchronous clear of count and carry
out  output  CHANNELS  replay pulse, high for exactly stored-count cycles
done  output  CHANNELS  one-cycle pulse after replay ends
carry  output  CHANNELS  sticky overflow flag
busy  output  CHANNELS  high while channel is in WRITE or READ
count  output  CHANNELS*BITS  stored count, channel i at [i*BITS +: BITS]

Behaviour:
- Interface (decided): one clock, clk; reset rst is asynchronous and active-high. While rst is high, every channel is forced to IDLE; count=0, carry=0, out=0, done=0, busy=0. Reset mid-WRITE or mid-READ aborts immediately with no done pulse.
- Channel states: IDLE (holds a count, possibly 0), WRITE, READ. Each channel is independent.
- IDLE->WRITE:
  - Trigger: cycle k where we is sampled high.
  - count increments in cycle k, so count=old+1 visible at k+1.
  - Writes accumulate onto the held count; clr first for a fresh interval.
- WRITE:
  - count += 1 on every cycle we is high.
  - The first cycle we is sampled low, return to IDLE with count unchanged.
  - A pulse of W cycles from count 0 stores W.
- Overflow:
  - Incrementing from all-ones sets carry.
  - SATURATE=0: count wraps to 0.
  - SATURATE=1: count stays all-ones.
  - carry is sticky until clr, rst or read completion.
- IDLE->READ:
  - Trigger: rising edge of re (sampled high at cycle k, low at k-1) while in IDLE.
  - out is high in cycles k+1..k+C, where C is count at cycle k.
  - count decrements each out-high cycle; done=1 in cycle k+C+1.
  - Then IDLE with count=0 and carry=0.
  - C=0: out never asserts and done pulses at k+1.
- re held high after replay does not retrigger; a new rising edge is required.
- busy = (state != IDLE). out is registered and glitch-free.
- Priorities in IDLE on the same cycle: we beats a re edge. The re edge is consumed and not deferred.
- Ignored strobes:
  - re during WRITE is ignored; its edge is lost.
  - we during READ is ignored; the replay completes undisturbed.
- clr:
  - In IDLE: count=0 and carry=0 next cycle.
  - In WRITE: zeroes count, and counting continues from 1 if we is still high.
  - In READ: aborts the replay; out drops next cycle, no done pulse, return to IDLE.
  - clr has priority over we/re in the same cycle.
- Channels share nothing but clk/rst; activity on one channel never alters another's outputs.

Decomposition:
- Shared package/include tff_pkg:
  - state encodings ST_IDLE, ST_WRITE, ST_READ (2 bits)
  - overflow-mode constants MODE_WRAP=0, MODE_SAT=1
- One natural sub-module: tff_chan, the single-channel FSM plus counter, parametrised by BITS and SATURATE.
- tff_bank instantiates CHANNELS copies via generate and packs count.

Test Plan:
1. BITS=4: rst, we[0] high 5 cycles, re[0] edge -> out[0] high exactly 5 cycles starting the cycle after the re edge; done[0] one cycle later; count[0]=0, carry[0]=0 after.
2. Accumulate: we[1] pulses of 3 then 4 cycles, no clr -> count[1]=7; replay gives a 7-cycle out[1] pulse.
3. Overflow, BITS=4, we[2] high 18 cycles:
   - SATURATE=0 -> count=2, carry=1.
   - SATURATE=1 -> count=15, carry=1.
   - Read in either mode clears carry.
4. Collisions:
   - we[3] and re[3] edge in the same IDLE cycle -> WRITE, no replay.
   - re edge during WRITE -> no replay.
   - we during READ -> count unaffected, replay length unchanged.
5. Aborts:
   - rst asserted mid-READ (count 9, after 4 out cycles) -> out, busy, count=0 immediately; no done pulse.
   - Separately, clr mid-READ -> out low next cycle, no done pulse.
6. Edge cases:
   - re edge with count 0 -> done at k+1, out never high.
   - re held high 20 cycles after replay -> only one done pulse.
   - Concurrent ops on all 4 channels -> each channel's counts independent.
